// File: rtl/module_bin_to_bcd_seq_if.sv
// Handshake and payload bundle between a requester and the sequential binary-to-BCD converter.
// Signal names are from the converter's point of view (i_* into it, o_* out of it).
interface module_bin_to_bcd_seq_if #(
    parameter int unsigned BIN_W  = 12,
    parameter int unsigned DIGITS = 4
);
    localparam int unsigned ND_W = $clog2(DIGITS + 1);

    logic                  i_valid;
    logic                  o_ready;
    logic [BIN_W-1:0]      i_bin;
    logic                  i_signed;
    logic                  o_valid;
    logic                  i_ready;
    logic [4*DIGITS-1:0]   o_bcd;
    logic                  o_neg;
    logic [ND_W-1:0]       o_ndigits;

    modport slave (
        input  i_valid, i_bin, i_signed, i_ready,
        output o_ready, o_valid, o_bcd, o_neg, o_ndigits
    );

    modport master (
        output i_valid, i_bin, i_signed, i_ready,
        input  o_ready, o_valid, o_bcd, o_neg, o_ndigits
    );
endinterface

// File: rtl/module_bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one operand bit per clock,
// with optional two's-complement input (sign + magnitude result) and significant-digit count.
module module_bin_to_bcd_seq #(
    parameter int unsigned BIN_W  = 12,
    parameter int unsigned DIGITS = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    module_bin_to_bcd_seq_if.slave    bus
);
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned ND_W  = $clog2(DIGITS + 1);
    localparam int unsigned BCD_W = 4 * DIGITS;

    // Decimal digits needed to print 2**w-1, i.e. smallest D with 10**D >= 2**w.
    function automatic int unsigned dec_digits(input int unsigned w);
        longint unsigned m;
        int unsigned     n;
        m = (64'd1 << w) - 64'd1;
        n = 0;
        for (int i = 0; i < 24; i++) begin
            if (m != 64'd0) begin
                n = n + 1;
                m = m / 64'd10;
            end
        end
        return n;
    endfunction

    localparam int unsigned NEED_DIG = dec_digits(BIN_W);

    if (BIN_W < 4 || BIN_W > 32) begin : g_bad_bin_w
        $fatal(1, "module_bin_to_bcd_seq: BIN_W=%0d outside 4..32", BIN_W);
    end
    if (DIGITS < NEED_DIG) begin : g_bad_digits
        $fatal(1, "module_bin_to_bcd_seq: DIGITS=%0d cannot hold 2**%0d-1", DIGITS, BIN_W);
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   mag_q, mag_d;
    logic [BCD_W-1:0]   wbcd_q, wbcd_d;
    logic               wneg_q, wneg_d;
    logic               ready_q, ready_d;
    logic               valid_q, valid_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               neg_q, neg_d;
    logic [ND_W-1:0]    nd_q, nd_d;

    logic [BCD_W-1:0]   bcd_adj_c;
    logic [BCD_W-1:0]   bcd_shift_c;
    logic [BIN_W-1:0]   mag_shift_c;
    logic [ND_W-1:0]    nd_c;

    // One double-dabble step: add-3 on every digit >= 5, then shift magnitude MSB into BCD.
    always_comb begin
        bcd_adj_c = wbcd_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (wbcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj_c[4*i +: 4] = wbcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_shift_c = {bcd_adj_c[BCD_W-2:0], mag_q[BIN_W-1]};
        mag_shift_c = {mag_q[BIN_W-2:0], 1'b0};
        nd_c = ND_W'(1);
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_shift_c[4*i +: 4] != 4'd0) begin
                nd_c = ND_W'(i + 1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mag_q   <= '0;
            wbcd_q  <= '0;
            wneg_q  <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
            nd_q    <= ND_W'(1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mag_q   <= mag_d;
            wbcd_q  <= wbcd_d;
            wneg_q  <= wneg_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            bcd_q   <= bcd_d;
            neg_q   <= neg_d;
            nd_q    <= nd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mag_d   = mag_q;
        wbcd_d  = wbcd_q;
        wneg_d  = wneg_q;
        ready_d = ready_q;
        valid_d = valid_q;
        bcd_d   = bcd_q;
        neg_d   = neg_q;
        nd_d    = nd_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.i_valid) begin
                    // Most-negative input negates to 2**(BIN_W-1), which still fits unsigned.
                    if (bus.i_signed && bus.i_bin[BIN_W-1]) begin
                        mag_d  = ~bus.i_bin + BIN_W'(1);
                        wneg_d = 1'b1;
                    end else begin
                        mag_d  = bus.i_bin;
                        wneg_d = 1'b0;
                    end
                    wbcd_d  = '0;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                wbcd_d = bcd_shift_c;
                mag_d  = mag_shift_c;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    bcd_d   = bcd_shift_c;
                    neg_d   = wneg_q && (bcd_shift_c != '0);
                    nd_d    = nd_c;
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.i_ready) begin
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
                valid_d = 1'b0;
            end
        endcase
    end

    assign bus.o_ready   = ready_q;
    assign bus.o_valid   = valid_q;
    assign bus.o_bcd     = bcd_q;
    assign bus.o_neg     = neg_q;
    assign bus.o_ndigits = nd_q;
endmodule

// File: doc/module_bin_to_bcd_seq.md
Name: module_bin_to_bcd_seq

Overview:
- Multi-cycle, parametrised binary-to-BCD converter using sequential double-dabble (shift-add-3), one bit per clock.
- Has a valid/ready handshake on both input and output.
- Supports optional two's-complement input (sign + magnitude output).
- Reports the significant-digit count so downstream 7-segment drivers can blank leading zeros.
- Replaces the combinational converter where BIN_W grows and the unrolled add-3 chain breaks timing.

Parameters:
- BIN_W, 12, binary input width. Legal range 4..32.
- DIGITS, 4, number of BCD output digits. Elaboration must $fatal unless 10**DIGITS >= 2**BIN_W.
- CNT_W, $clog2(BIN_W+1), shift-counter width. Derived; not overridden.

Ports:
- i_clk  in  1  clock; all logic rising-edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  input request.
- o_ready  out  1  converter idle, can accept.
- i_bin  in  BIN_W  binary operand.
- i_signed  in  1  1 = treat i_bin as two's complement. Sampled with i_bin.
- o_valid  out  1  result available.
- i_ready  in  1  consumer accepts result.
- o_bcd  out  4*DIGITS  BCD magnitude; digit 0 in [3:0].
- o_neg  out  1  result is negative.
- o_ndigits  out  $clog2(DIGITS+1)  count of significant digits, 1..DIGITS.

Behaviour:
- One clock; reset is synchronous and active-high (i_clk, i_rst).
- Reset values:
  - State IDLE, o_ready=1, o_valid=0.
  - o_bcd=0, o_neg=0, o_ndigits=1.
  - Working registers and counter = 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - o_ready=1.
  - On an edge with i_valid=1, capture the operand and go to SHIFT with count=0.
  - Magnitude = i_bin, except when i_signed=1 and i_bin[BIN_W-1]=1: magnitude = (~i_bin)+1 as an unsigned BIN_W-bit value, and neg_r=1.
  - -2**(BIN_W-1) yields magnitude 2**(BIN_W-1); there is no overflow.
  - Working BCD register cleared.
- SHIFT:
  - o_ready=0.
  - Each edge: every working digit >=5 gets +3 (all digits in parallel, from the pre-shift value), then {bcd,mag} shifts left by 1 with mag MSB entering bcd bit 0. count++.
  - On the edge where count reaches BIN_W-1 (the BIN_W-th shift):
    - Load o_bcd with the final shifted value.
    - o_neg = neg_r AND (magnitude != 0).
    - o_ndigits = index of the highest nonzero digit + 1 (1 if zero).
    - o_valid=1, go to DONE.
- DONE:
  - o_valid=1; o_bcd, o_neg and o_ndigits stay stable.
  - When i_ready=1 on an edge: o_valid=0, go to IDLE.
  - i_valid is ignored (o_ready=0).
- Latency: accept edge E0; o_valid is high after edge E(BIN_W).
  - With i_ready tied high, throughput is one result per BIN_W+2 cycles.
  - No overlap of accept and output handshakes.
- o_bcd/o_neg/o_ndigits hold the last result through IDLE and SHIFT until the next DONE entry. They are not cleared on handshake.
- Operand changes on i_bin/i_signed after the accept edge have no effect.
- i_rst at any state, including mid-SHIFT or DONE, aborts the conversion. Every output returns to its reset value on that edge, and no partial result is emitted.
- Digits never exceed 9 at any stage. Unused upper digits read 0.

Test Plan:
- Reset: assert i_rst 2 cycles -> o_ready=1, o_valid=0, o_bcd=0x0000, o_neg=0, o_ndigits=1. Default params.
- Unsigned max: i_bin=12'hFFF, i_signed=0, i_ready=1 -> o_valid high exactly 12 edges after accept, o_bcd=0x4095, o_neg=0, o_ndigits=4; o_ready returns 1 one edge later.
- Signed cases:
  - 12'h800, i_signed=1 -> o_bcd=0x2048, o_neg=1, o_ndigits=4.
  - 12'hFFF, i_signed=1 -> o_bcd=0x0001, o_neg=1, o_ndigits=1.
  - 12'h000, i_signed=1 -> o_bcd=0x0000, o_neg=0, o_ndigits=1.
- Backpressure: convert 12'd907, hold i_ready=0 for 5 cycles while pulsing i_valid with 12'd1 -> o_bcd stays 0x0907, o_ndigits=3, o_ready=0, second request not taken. After i_ready=1, o_valid drops and the next request converts to 0x0001.
- Reset mid-op: accept 12'd1234, assert i_rst after 5 SHIFT edges -> outputs at reset values, no o_valid pulse. Then convert 12'd1234 -> o_bcd=0x1234.
- Alternate params BIN_W=8, DIGITS=3:
  - 8'hFF unsigned -> 0x255, o_valid after 8 edges.
  - 8'h80 signed -> 0x128, o_neg=1.
  - BIN_W=10, DIGITS=3 -> elaboration fatal (1000 < 1024).
